univ_shift_reg_burst: RTL and testbench

//  Parametrised universal shift register; successor to the fixed 4-bit left/right shifters.
//  - Adds configurable width and a compile-time policy for simultaneous left+right.
//  - Adds arithmetic right shift and a counted multi-cycle burst shift with busy/done handshake.
//  - Serial/parallel converter for datapath and serial-link blocks in this design.

---
 rtl/univ_shift_reg_burst.sv | 139 +++++++++++++
 tb/tb_univ_shift_reg_burst.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with parallel load, arithmetic right shift and counted burst shifting.
// Optional rotate support is enabled at compile time with SHREG_ROTATE_EN.
module univ_shift_reg_burst #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned CONFLICT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             left,
    input  logic             right,
    input  logic             shift_in,
    input  logic             arith,
    input  logic             rot,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

`ifdef SHREG_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    dir_t             dir_c;
    dir_t             lat_dir, lat_dir_nxt;
    logic             lat_arith, lat_arith_nxt;
    logic             lat_rot, lat_rot_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             rot_eff_c;

    // Rotate request is masked to zero when the feature is compiled out
    assign rot_eff_c = rot & ROT_EN;

    // Returns {bit shifted out, new register value}; rotate overrides arithmetic fill
    function automatic logic [WIDTH:0] shift_fn(input logic [WIDTH-1:0] v, input dir_t d,
                                                input logic a, input logic r, input logic si);
        logic sin;
        sin = si;
        if (d == DIR_L) begin
            if (r) sin = v[WIDTH-1];
            return {v[WIDTH-1], v[WIDTH-2:0], sin};
        end
        if (r)      sin = v[0];
        else if (a) sin = v[WIDTH-1];
        return {v[0], sin, v[WIDTH-1:1]};
    endfunction

    // Direction resolve with compile-time policy for left and right together
    always_comb begin
        dir_c = DIR_NONE;
        if (left && !right)      dir_c = DIR_L;
        else if (right && !left) dir_c = DIR_R;
        else if (left && right) begin
            if (CONFLICT == 0)      dir_c = DIR_L;
            else if (CONFLICT == 1) dir_c = DIR_R;
            else                    dir_c = DIR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            q         <= '0;
            shift_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            lat_dir   <= DIR_NONE;
            lat_arith <= 1'b0;
            lat_rot   <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            shift_out <= so_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            cnt       <= cnt_nxt;
            lat_dir   <= lat_dir_nxt;
            lat_arith <= lat_arith_nxt;
            lat_rot   <= lat_rot_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        so_nxt        = shift_out;
        cnt_nxt       = cnt;
        lat_dir_nxt   = lat_dir;
        lat_arith_nxt = lat_arith;
        lat_rot_nxt   = lat_rot;

        case (state)
            S_IDLE: begin
                if (load) begin
                    q_nxt = data;
                end else if (burst_start && dir_c != DIR_NONE) begin
                    lat_dir_nxt   = dir_c;
                    lat_arith_nxt = arith;
                    lat_rot_nxt   = rot_eff_c;
                    cnt_nxt       = burst_cnt;
                    state_nxt     = (burst_cnt == '0) ? S_DONE : S_BURST;
                end else if (dir_c != DIR_NONE) begin
                    {so_nxt, q_nxt} = shift_fn(q, dir_c, arith, rot_eff_c, shift_in);
                end
            end
            S_BURST: begin
                {so_nxt, q_nxt} = shift_fn(q, lat_dir, lat_arith, lat_rot, shift_in);
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_BURST);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Self-checking bench for univ_shift_reg_burst: directed scenarios plus randomized shifts and bursts.
module tb_univ_shift_reg_burst;

`ifdef SHREG_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, load, left, right, shift_in, arith, rot, burst_start;
    logic [3:0] burst_cnt;
    logic [7:0] data;
    logic [7:0] q, q0, q1;
    logic       shift_out, busy, done;
    logic       so0, busy0, done0, so1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4), .CONFLICT(2)) dut (
        .clk(clk), .reset(reset), .load(load), .left(left), .right(right), .shift_in(shift_in),
        .arith(arith), .rot(rot), .burst_start(burst_start), .burst_cnt(burst_cnt), .data(data),
        .q(q), .shift_out(shift_out), .busy(busy), .done(done));

    univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4), .CONFLICT(0)) dut_c0 (
        .clk(clk), .reset(reset), .load(load), .left(left), .right(right), .shift_in(shift_in),
        .arith(arith), .rot(rot), .burst_start(burst_start), .burst_cnt(burst_cnt), .data(data),
        .q(q0), .shift_out(so0), .busy(busy0), .done(done0));

    univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4), .CONFLICT(1)) dut_c1 (
        .clk(clk), .reset(reset), .load(load), .left(left), .right(right), .shift_in(shift_in),
        .arith(arith), .rot(rot), .burst_start(burst_start), .burst_cnt(burst_cnt), .data(data),
        .q(q1), .shift_out(so1), .busy(busy1), .done(done1));

    // Reference shift: returns {bit out, new value}
    function automatic logic [8:0] mshift(input logic [7:0] v, input bit to_left, input bit ar,
                                          input bit ro, input bit si);
        logic       b;
        logic [7:0] r;
        if (to_left) begin
            b = (ROT_EN && ro) ? v[7] : si;
            r = (v << 1) | {7'd0, b};
            return {v[7], r};
        end
        b = (ROT_EN && ro) ? v[0] : (ar ? v[7] : si);
        r = (v >> 1) | {b, 7'd0};
        return {v[0], r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        load = 0; left = 0; right = 0; shift_in = 0; arith = 0; rot = 0;
        burst_start = 0; burst_cnt = 0; data = 0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1; data = v;
        tick();
        load = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 0;
        #12;
        checks++;
        if ({q, shift_out, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: q=%h so=%b busy=%b done=%b, required all zero", q, shift_out, busy, done);
        end
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    task automatic test_single_shift;
        do_load(8'h81);
        left = 1; shift_in = 0;
        tick();
        left = 0;
        checks++;
        if (q !== 8'h02 || shift_out !== 1'b1) begin
            errors++;
            $display("FAIL single_left: q=%h so=%b, required q=02 so=1", q, shift_out);
        end
        do_load(8'h81);
        right = 1; arith = 1; shift_in = 0;
        tick();
        right = 0; arith = 0;
        checks++;
        if (q !== 8'hC0 || shift_out !== 1'b1) begin
            errors++;
            $display("FAIL single_right_arith: q=%h so=%b, required q=c0 so=1", q, shift_out);
        end
    endtask

    task automatic test_conflict;
        do_load(8'h81);
        left = 1; right = 1; shift_in = 1;
        tick();
        left = 0; right = 0; shift_in = 0;
        checks++;
        if (q0 !== 8'h03) begin
            errors++;
            $display("FAIL conflict_left_wins: q=%h, required 03", q0);
        end
        checks++;
        if (q1 !== 8'hC0) begin
            errors++;
            $display("FAIL conflict_right_wins: q=%h, required c0", q1);
        end
        checks++;
        if (q !== 8'h81) begin
            errors++;
            $display("FAIL conflict_hold: q=%h, required 81", q);
        end
    endtask

    task automatic test_burst;
        int busy_cycles;
        do_load(8'hF0);
        burst_start = 1; right = 1; burst_cnt = 4; shift_in = 0;
        tick();
        burst_start = 0; right = 0;
        load = 1; data = 8'hFF;
        busy_cycles = 0;
        for (int k = 1; k <= 6 && !done; k++) begin
            if (busy) busy_cycles++;
            tick();
        end
        load = 0;
        checks++;
        if (busy_cycles != 4 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_timing: busy_cycles=%0d done=%b busy=%b, required 4/1/0", busy_cycles, done, busy);
        end
        checks++;
        if (q !== 8'h0F) begin
            errors++;
            $display("FAIL burst_result: q=%h, required 0f", q);
        end
        tick();
        checks++;
        if (done !== 1'b0 || q !== 8'h0F) begin
            errors++;
            $display("FAIL burst_done_pulse: done=%b q=%h, required 0 and 0f", done, q);
        end
    endtask

    task automatic test_burst_zero;
        logic [7:0] held;
        held = q;
        burst_start = 1; left = 1; burst_cnt = 0;
        tick();
        burst_start = 0; left = 0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== held) begin
            errors++;
            $display("FAIL burst_zero: done=%b busy=%b q=%h, required 1/0/%h", done, busy, q, held);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL burst_zero_pulse: done=%b, required 0", done);
        end
        burst_start = 1; burst_cnt = 3;
        tick();
        tick();
        burst_start = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== held) begin
            errors++;
            $display("FAIL burst_no_dir: busy=%b done=%b q=%h, required 0/0/%h", busy, done, q, held);
        end
    endtask

    task automatic test_rotate;
        logic [7:0] expq;
        expq = ROT_EN ? 8'h0C : 8'h08;
        do_load(8'h81);
        burst_start = 1; left = 1; rot = 1; burst_cnt = 3; shift_in = 0;
        tick();
        burst_start = 0; left = 0; rot = 0;
        for (int k = 0; k < 6 && !done; k++) tick();
        checks++;
        if (q !== expq || done !== 1'b1) begin
            errors++;
            $display("FAIL rotate_burst: q=%h done=%b, required %h and 1", q, done, expq);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst;
        int pulses;
        do_load(8'hA5);
        burst_start = 1; left = 1; burst_cnt = 8;
        tick();
        burst_start = 0; left = 0;
        tick();
        #2 reset = 0;
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shift_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: q=%h busy=%b done=%b so=%b, required all zero", q, busy, done, shift_out);
        end
        tick();
        @(negedge clk);
        reset = 1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0 || q !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: busy/done cycles=%0d q=%h, required 0 and 00", pulses, q);
        end
    endtask

    task automatic test_random_single;
        logic [7:0] mq;
        logic       mso;
        bit         so_known;
        logic [8:0] r;
        mq = 8'($urandom);
        do_load(mq);
        so_known = 0;
        mso = 0;
        for (int i = 0; i < 200; i++) begin
            load = ($urandom_range(0, 7) == 0);
            data = 8'($urandom);
            left = 1'($urandom); right = 1'($urandom);
            arith = 1'($urandom); rot = 1'($urandom); shift_in = 1'($urandom);
            if (load) mq = data;
            else if (left != right) begin
                r = mshift(mq, left, arith, rot, shift_in);
                {mso, mq} = r;
                so_known = 1;
            end
            tick();
            checks++;
            if (q !== mq || busy !== 1'b0 || (so_known && shift_out !== mso)) begin
                errors++;
                $display("FAIL random_single[%0d]: q=%h so=%b busy=%b, required q=%h so=%b busy=0",
                         i, q, shift_out, busy, mq, mso);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random_burst;
        logic [7:0] mq;
        logic       mso;
        bit         to_left, ar, ro;
        int         n, bad;
        logic [8:0] r;
        for (int b = 0; b < 20; b++) begin
            mq = 8'($urandom);
            do_load(mq);
            n = $urandom_range(0, 15);
            to_left = 1'($urandom); ar = 1'($urandom); ro = 1'($urandom);
            burst_start = 1; left = to_left; right = !to_left;
            arith = ar; rot = ro; burst_cnt = 4'(n);
            tick();
            bad = 0;
            for (int k = 1; k <= n; k++) begin
                if (busy !== 1'b1 || done !== 1'b0) bad++;
                load = 1'($urandom); data = 8'($urandom);
                left = 1'($urandom); right = 1'($urandom);
                arith = 1'($urandom); rot = 1'($urandom);
                burst_start = 1'($urandom); burst_cnt = 4'($urandom);
                shift_in = 1'($urandom);
                r = mshift(mq, to_left, ar, ro, shift_in);
                {mso, mq} = r;
                tick();
            end
            idle_inputs();
            checks++;
            if (bad != 0 || busy !== 1'b0 || done !== 1'b1 || q !== mq || (n > 0 && shift_out !== mso)) begin
                errors++;
                $display("FAIL random_burst[%0d] n=%0d: q=%h so=%b busy=%b done=%b bad_busy=%0d, required q=%h so=%b busy=0 done=1",
                         b, n, q, shift_out, busy, done, bad, mq, mso);
            end
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== mq) begin
                errors++;
                $display("FAIL random_burst_end[%0d]: done=%b busy=%b q=%h, required 0/0/%h", b, done, busy, q, mq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_shift();
        test_conflict();
        test_burst();
        test_burst_zero();
        test_rotate();
        test_reset_mid_burst();
        test_random_single();
        test_random_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
